// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the requester-side and fifo_syn-side signals of the shared write-port arbiter.
// Handshake: a requester beat moves on a rising clk edge when req_valid[i] && req_ready[i];
// while req_valid[i] && !req_ready[i] the requester holds req_data slice i stable.
// The fifo side sees a write whenever fifo_cs && fifo_wr_en, which only happens while !fifo_full.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_cs;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          grant_valid;
    logic [ID_W-1:0]               grant_id;
    logic                          fsm_state;   // debug view: 0 = IDLE, 1 = GRANT

    // Producers and the fifo model drive the arbiter through this side.
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_cs, fifo_wr_en, fifo_data_in, grant_valid, grant_id, fsm_state
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_cs, fifo_wr_en, fifo_data_in, grant_valid, grant_id, fsm_state
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_syn write port among NUM_REQ producers.
// The winner keeps the port for up to MAX_BURST accepted beats, then the grant
// rotates; a release with another requester waiting hands over without a bubble.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input logic                clk,
    input logic                rst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   owner, owner_nxt;
    logic [ID_W-1:0]   last, last_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_nxt;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   scan_id;
    logic              xfer;
    logic              release_now;

    // Round-robin scan starting just after 'last'. In GRANT last == owner, so the
    // current owner is visited last and only wins again if it is still valid.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_id = ID_W'((int'(last) + k) % NUM_REQ);
            if (!pick_found && bus.req_valid[scan_id]) begin
                pick_found = 1'b1;
                pick_idx   = scan_id;
            end
        end
    end

    // FSM next-state plus the combinational port outputs.
    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        last_nxt         = last;
        beat_nxt         = beat_cnt;
        release_now      = 1'b0;
        bus.req_ready    = '0;
        bus.fifo_data_in = '0;
        bus.grant_valid  = 1'b0;
        bus.grant_id     = '0;

        xfer = (state == GRANT) && bus.req_valid[owner] && !bus.fifo_full;

        if (state == GRANT) begin
            bus.grant_valid  = 1'b1;
            bus.grant_id     = owner;
            bus.fifo_data_in = bus.req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
            if (!bus.fifo_full) begin
                bus.req_ready[owner] = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_nxt = GRANT;
                    owner_nxt = pick_idx;
                    last_nxt  = pick_idx;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                // A stalled beat (fifo_full) is not an xfer, so it never counts.
                if (xfer) begin
                    beat_nxt = beat_cnt + 1'b1;
                end
                release_now = (xfer && (beat_cnt == CNT_W'(MAX_BURST - 1)))
                              || !bus.req_valid[owner];
                if (release_now) begin
                    beat_nxt = '0;
                    if (pick_found) begin
                        owner_nxt = pick_idx;
                        last_nxt  = pick_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.fifo_wr_en = xfer;
    assign bus.fifo_cs    = xfer;
    assign bus.fsm_state  = (state == GRANT);

    // State register; 'last' resets to the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            beat_cnt <= beat_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural rotation model.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] base[N];
    int            seq[N];
    logic [N-1:0]  last_acc;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs at negedge, let outputs settle, note accepted beats.
    task automatic drive(input logic [N-1:0] v, input logic full, input logic r);
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.fifo_full = full;
        for (int i = 0; i < N; i++) begin
            bus.req_data[i*DW +: DW] = base[i] + DW'(seq[i]);
        end
        #3;
        last_acc = bus.req_valid & bus.req_ready;
        for (int i = 0; i < N; i++) begin
            if (last_acc[i]) seq[i]++;
        end
    endtask

    task automatic reset_all();
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            base[i] = DW'(32'h100 * (i + 1));
        end
        drive('0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    function automatic int rr_from(input int start, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    bit m_ok = 1'b0;
    bit m_busy;
    int m_own, m_last, m_beats;

    initial begin
        logic         e_xfer;
        logic [N-1:0] e_ready;
        logic [DW-1:0] e_data;
        int p;
        forever begin
            @(negedge clk);
            #2;
            e_xfer  = m_busy && bus.req_valid[m_own] && !bus.fifo_full;
            e_ready = '0;
            if (m_busy && !bus.fifo_full) e_ready[m_own] = 1'b1;
            e_data  = m_busy ? bus.req_data[m_own*DW +: DW] : '0;
            if (m_ok) begin
                chk("m_grant_valid", DW'(bus.grant_valid), DW'(m_busy));
                chk("m_grant_id", DW'(bus.grant_id), m_busy ? DW'(m_own) : '0);
                chk("m_req_ready", DW'(bus.req_ready), DW'(e_ready));
                chk("m_wr_en", DW'(bus.fifo_wr_en), DW'(e_xfer));
                chk("m_cs", DW'(bus.fifo_cs), DW'(e_xfer));
                chk("m_data_in", bus.fifo_data_in, e_data);
                if (e_xfer) exp_q.push_back(e_data);
                if (bus.fifo_wr_en === 1'b1) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_extra: got write %0h want none at %0t", bus.fifo_data_in, $time);
                    end else begin
                        e_data = exp_q.pop_front();
                        if (bus.fifo_data_in !== e_data) begin
                            n_bad++;
                            $display("FAIL sb_data: got %0h want %0h at %0t", bus.fifo_data_in, e_data, $time);
                        end
                    end
                end
            end
            // model advance to the next edge
            if (rst) begin
                m_ok = 1'b1; m_busy = 1'b0; m_own = 0; m_last = N - 1; m_beats = 0;
            end else if (m_ok && !m_busy) begin
                p = rr_from(m_last, bus.req_valid);
                if (p >= 0) begin
                    m_busy = 1'b1; m_own = p; m_last = p; m_beats = 0;
                end
            end else if (m_ok) begin
                if (e_xfer) m_beats++;
                if ((e_xfer && m_beats == MB) || !bus.req_valid[m_own]) begin
                    p = rr_from(m_own, bus.req_valid);
                    m_beats = 0;
                    if (p >= 0) begin
                        m_own = p; m_last = p;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] v;
        logic         f;
        logic         r;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        last_acc      = '0;

        // Single requester: 1-cycle latency, 4-beat burst, bubble-free re-grant, then drop to IDLE.
        reset_all();
        base[0] = 32'hA0;
        drive(4'b0001, 1'b0, 1'b0);
        chk("t1_first_cycle_wr", DW'(bus.fifo_wr_en), 0);
        for (int k = 0; k < 6; k++) begin
            drive(4'b0001, 1'b0, 1'b0);
            chk("t1_wr", DW'(bus.fifo_wr_en), 1);
            chk("t1_data", bus.fifo_data_in, 32'hA0 + DW'(k));
            chk("t1_gid", DW'(bus.grant_id), 0);
        end
        drive(4'b0000, 1'b0, 1'b0);
        chk("t6_drop_wr", DW'(bus.fifo_wr_en), 0);
        drive(4'b0000, 1'b0, 1'b0);
        chk("t6_idle_gv", DW'(bus.grant_valid), 0);
        chk("t6_idle_gid", DW'(bus.grant_id), 0);
        chk("t6_idle_ready", DW'(bus.req_ready), 0);
        chk("t6_idle_data", bus.fifo_data_in, 0);

        // All requesters valid: 0,1,2,3 each for exactly 4 beats, then back to 0.
        reset_all();
        drive(4'b1111, 1'b0, 1'b0);
        chk("t2_idle_gv", DW'(bus.grant_valid), 0);
        for (int k = 0; k < 17; k++) begin
            drive(4'b1111, 1'b0, 1'b0);
            chk("t2_gid", DW'(bus.grant_id), DW'((k / 4) % N));
            chk("t2_wr", DW'(bus.fifo_wr_en), 1);
            chk("t2_onehot", DW'($countones(bus.req_ready)), 1);
            chk("t2_data", bus.fifo_data_in, DW'(32'h100 * ((k / 4) % N + 1) + (k < 16 ? k % 4 : 4)));
        end

        // Req 2 stalled for 3 cycles after its 2nd beat; burst still totals 4 beats.
        reset_all();
        drive(4'b1100, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(4'b1100, 1'b0, 1'b0);
            chk("t3_gid", DW'(bus.grant_id), 2);
            chk("t3_wr", DW'(bus.fifo_wr_en), 1);
        end
        for (int k = 0; k < 3; k++) begin
            drive(4'b1100, 1'b1, 1'b0);
            chk("t3_stall_wr", DW'(bus.fifo_wr_en), 0);
            chk("t3_stall_ready", DW'(bus.req_ready), 0);
            chk("t3_stall_gid", DW'(bus.grant_id), 2);
        end
        for (int k = 2; k < 4; k++) begin
            drive(4'b1100, 1'b0, 1'b0);
            chk("t3_wr2", DW'(bus.fifo_wr_en), 1);
            chk("t3_data2", bus.fifo_data_in, 32'h300 + DW'(k));
        end
        drive(4'b1100, 1'b0, 1'b0);
        chk("t3_next_gid", DW'(bus.grant_id), 3);

        // Req 1 drops valid after 2 beats; req 3 takes over with no idle cycle.
        reset_all();
        drive(4'b1010, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(4'b1010, 1'b0, 1'b0);
            chk("t4_gid1", DW'(bus.grant_id), 1);
        end
        drive(4'b1000, 1'b0, 1'b0);
        chk("t4_drop_gv", DW'(bus.grant_valid), 1);
        chk("t4_drop_wr", DW'(bus.fifo_wr_en), 0);
        drive(4'b1000, 1'b0, 1'b0);
        chk("t4_handoff_gid", DW'(bus.grant_id), 3);
        chk("t4_handoff_wr", DW'(bus.fifo_wr_en), 1);
        chk("t4_req1_beats", DW'(seq[1]), 2);

        // Reset during req 0's 3rd beat.
        reset_all();
        drive(4'b1111, 1'b0, 1'b0);
        drive(4'b1111, 1'b0, 1'b0);
        drive(4'b1111, 1'b0, 1'b0);
        drive(4'b1111, 1'b0, 1'b1);
        chk("t5_inflight_wr", DW'(bus.fifo_wr_en), 1);
        drive(4'b1111, 1'b0, 1'b0);
        chk("t5_rst_gv", DW'(bus.grant_valid), 0);
        chk("t5_rst_ready", DW'(bus.req_ready), 0);
        chk("t5_rst_wr", DW'(bus.fifo_wr_en), 0);
        drive(4'b1111, 1'b0, 1'b0);
        chk("t5_regrant_gid", DW'(bus.grant_id), 0);
        chk("t5_regrant_gv", DW'(bus.grant_valid), 1);

        // Random traffic against the model.
        reset_all();
        for (int i = 0; i < N; i++) base[i] = DW'(i) << 24;
        v = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && last_acc[i])  v[i] = ($urandom_range(0, 99) < 70);
                else if (v[i])            v[i] = ($urandom_range(0, 99) >= 5);
                else                      v[i] = ($urandom_range(0, 99) < 40);
            end
            f = ($urandom_range(0, 99) < 20);
            r = ($urandom_range(0, 299) == 0);
            drive(v, f, r);
        end
        drive('0, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        chk("sb_leftover", DW'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
